// File: rtl/mem_arb_pkg.sv
// Owner encoding, grant bit positions and default widths shared by the memory port arbiter.
// Round-robin arbitration is selected with `define MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  localparam int unsigned GNT_INST = 0;
  localparam int unsigned GNT_DATA = 1;

  function automatic owner_e gnt_owner(input logic [1:0] gnt);
    return gnt[GNT_DATA] ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way chooser returning a one-hot grant {data, inst}.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  owner_e     last_win,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (inst_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Whoever lost the previous contended grant wins this one.
      if (last_win == OWN_DATA) begin
        gnt[GNT_INST] = 1'b1;
      end else begin
        gnt[GNT_DATA] = 1'b1;
      end
`else
      gnt[GNT_DATA] = 1'b1;
`endif
    end else begin
      gnt[GNT_INST] = inst_req;
      gnt[GNT_DATA] = data_req;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_win;
  assign unused_last_win = last_win;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read SRAM between the fetch and load/store ports, one grant per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention handling (default: data wins).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic [1:0]        gnt;
  logic              inst_live, data_live;
  logic              resp_valid_q, resp_valid_d;
  owner_e            resp_owner_q, resp_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  owner_e            last_win;

  // No grants while reset is held.
  assign inst_live = inst_req & ~reset;
  assign data_live = data_req & ~reset;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e ptr_q, ptr_d;

  assign last_win = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inst_live && data_live) begin
      ptr_d = gnt_owner(gnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= OWN_INST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign last_win = OWN_INST;
`endif

  mem_arb_pick u_pick (
    .inst_req (inst_live),
    .data_req (data_live),
    .last_win (last_win),
    .gnt      (gnt)
  );

  always_comb begin
    sram_we = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (gnt)
      2'b01: addr_d = inst_addr;
      2'b10: begin
        addr_d  = data_addr;
        wdata_d = data_wdata;
        sram_we = data_we;
      end
      default: ;
    endcase
    sram_en      = |gnt;
    sram_addr    = addr_d;
    sram_wdata   = wdata_d;
    resp_valid_d = |gnt;
    resp_owner_d = gnt_owner(gnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_INST;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Reset in the response cycle drops the in-flight response.
  always_comb begin
    inst_addr_ok = gnt[GNT_INST];
    data_addr_ok = gnt[GNT_DATA];
    inst_data_ok = resp_valid_q & ~reset & (resp_owner_q == OWN_INST);
    data_data_ok = resp_valid_q & ~reset & (resp_owner_q == OWN_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural SRAM and reference model.
// Follows MEM_ARB_ROUND_ROBIN_EN to pick the expected contention policy.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_addr_ok, data_data_ok;
  logic [3:0]  data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Synchronous-read SRAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= sram_mem[widx(sram_addr)];
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) sram_mem[widx(sram_addr)][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    to_pos();
    to_pos();
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    data_req = 1'b1; data_addr = a; data_wdata = d; data_we = we;
    to_neg();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL store_grant addr=%h: data_addr_ok=%b expected 1", a, data_addr_ok);
    end
    to_pos();
    data_req = 1'b0; data_we = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_addr = 32'h44; data_we = 4'hf;
    to_pos();
    to_pos();
    to_neg();
    checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: ok/en=%b expected 00000",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en});
    end
    checks++;
    if (sram_we !== 4'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: we=%h irdata=%h drdata=%h expected 0", sram_we, inst_rdata,
               data_rdata);
    end
    to_pos();
    reset = 1'b0;
    data_we = 4'h0;
    to_neg();
    // Pointer resets to INST, so the first contended grant goes to data in both policies.
    checks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: data_ok=%b inst_ok=%b expected 1 0", data_addr_ok,
               inst_addr_ok);
    end
    to_pos();
    idle_inputs();
    to_pos();
  endtask

  task automatic test_lone_fetch();
    do_reset();
    store(32'h1c000000, 32'h02800421, 4'hf);
    to_pos();
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    to_neg();
    checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || sram_en !== 1'b1 ||
        sram_we !== 4'h0 || sram_addr !== 32'h1c000000) begin
      errors++;
      $display("FAIL fetch_grant: iok=%b dok=%b en=%b we=%h addr=%h expected 1 0 1 0 1c000000",
               inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr);
    end
    to_pos();
    inst_req = 1'b0;
    to_neg();
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800421) begin
      errors++;
      $display("FAIL fetch_resp: ok=%b rdata=%h expected 1 02800421", inst_data_ok, inst_rdata);
    end
    checks++;
    if (data_addr_ok !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_data_quiet: aok=%b dok=%b rdata=%h expected 0 0 0", data_addr_ok,
               data_data_ok, data_rdata);
    end
    to_pos();
  endtask

  task automatic test_store_load();
    do_reset();
    data_req = 1'b1; data_we = 4'hf; data_addr = 32'h100; data_wdata = 32'hdeadbeef;
    to_neg();
    checks++;
    if (data_addr_ok !== 1'b1 || sram_we !== 4'hf || sram_wdata !== 32'hdeadbeef) begin
      errors++;
      $display("FAIL store_strobe: ok=%b we=%h wdata=%h expected 1 f deadbeef", data_addr_ok,
               sram_we, sram_wdata);
    end
    to_pos();
    data_we = 4'h0;
    to_neg();
    checks++;
    if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1 || sram_we !== 4'h0) begin
      errors++;
      $display("FAIL store_done_load_grant: dok=%b aok=%b we=%h expected 1 1 0", data_data_ok,
               data_addr_ok, sram_we);
    end
    to_pos();
    data_req = 1'b0;
    to_neg();
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hdeadbeef || inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL load_resp: ok=%b rdata=%h iok=%b expected 1 deadbeef 0", data_data_ok,
               data_rdata, inst_data_ok);
    end
    to_pos();
    store(32'h100, 32'h11223344, 4'b0011);
    data_req = 1'b1; data_addr = 32'h100;
    to_pos();
    data_req = 1'b0;
    to_neg();
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hdead3344) begin
      errors++;
      $display("FAIL partial_store: ok=%b rdata=%h expected 1 dead3344", data_data_ok,
               data_rdata);
    end
    to_pos();
  endtask

  task automatic test_contention();
    logic exp_d, prev_d, last_data;
    int   n_d;
    do_reset();
    last_data = 1'b0;
    prev_d = 1'b0;
    n_d = 0;
    inst_req = 1'b1; inst_addr = 32'h0;
    data_req = 1'b1; data_addr = 32'h100; data_we = 4'h0;
    for (int c = 0; c < 4; c++) begin
      to_neg();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = ~last_data;
`else
      exp_d = 1'b1;
`endif
      checks++;
      if (data_addr_ok !== exp_d || inst_addr_ok !== ~exp_d) begin
        errors++;
        $display("FAIL contend_grant c=%0d: dok=%b iok=%b expected %b %b", c, data_addr_ok,
                 inst_addr_ok, exp_d, ~exp_d);
      end
      if (c > 0) begin
        checks++;
        if (data_data_ok !== prev_d || inst_data_ok !== ~prev_d) begin
          errors++;
          $display("FAIL contend_owner c=%0d: ddok=%b idok=%b expected %b %b", c, data_data_ok,
                   inst_data_ok, prev_d, ~prev_d);
        end
      end
      prev_d = exp_d;
      last_data = exp_d;
      if (exp_d) n_d++;
      to_pos();
    end
    data_req = 1'b0;
    to_neg();
    checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL contend_release: iok=%b dok=%b expected 1 0", inst_addr_ok, data_addr_ok);
    end
    checks++;
    if (data_data_ok !== prev_d || inst_data_ok !== ~prev_d) begin
      errors++;
      $display("FAIL contend_last_owner: ddok=%b idok=%b expected %b %b", data_data_ok,
               inst_data_ok, prev_d, ~prev_d);
    end
    to_pos();
    idle_inputs();
    to_pos();
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0;
    to_neg();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL midreset_grant: iok=%b expected 1", inst_addr_ok);
    end
    to_pos();
    inst_req = 1'b0;
    reset = 1'b1;
    to_neg();
    checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_drop: idok=%b rdata=%h expected 0 0", inst_data_ok, inst_rdata);
    end
    to_pos();
    reset = 1'b0;
    to_neg();
    checks++;
    if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en} !== 5'b0 ||
        sram_we !== 4'h0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0 ||
        inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_after: oks/en=%b we=%h addr=%h wdata=%h expected all 0",
               {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en}, sram_we,
               sram_addr, sram_wdata);
    end
    to_pos();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      store(32'(4 * i), words[i], 4'hf);
    end
    to_pos();
    for (int i = 0; i < 4; i++) begin
      inst_req = (i < 3);
      inst_addr = 32'(4 * i);
      to_neg();
      if (i < 3) begin
        checks++;
        if (inst_addr_ok !== 1'b1) begin
          errors++;
          $display("FAIL b2b_grant i=%0d: iok=%b expected 1", i, inst_addr_ok);
        end
      end
      if (i > 0) begin
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== words[i-1]) begin
          errors++;
          $display("FAIL b2b_resp i=%0d: ok=%b rdata=%h expected 1 %h", i, inst_data_ok,
                   inst_rdata, words[i-1]);
        end
      end
      to_pos();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic        i_pend, d_pend, exp_gi, exp_gd, m_rv, m_own_d, m_read, last_win_d, ok;
    logic [31:0] m_rd, exp_addr;
    logic [3:0]  exp_we;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[widx(32'h800 + 32'(4 * i))] = $urandom;
      store(32'h800 + 32'(4 * i), ref_mem[widx(32'h800 + 32'(4 * i))], 4'hf);
    end
    to_pos();
    i_pend = 1'b0; d_pend = 1'b0; m_rv = 1'b0; m_own_d = 1'b0; m_read = 1'b0; m_rd = '0;
    last_win_d = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!i_pend && $urandom_range(0, 9) < 6) begin
        i_pend = 1'b1;
        inst_addr = 32'h800 + 32'(4 * $urandom_range(0, 15));
      end
      if (!d_pend && $urandom_range(0, 9) < 6) begin
        d_pend = 1'b1;
        data_addr = 32'h800 + 32'(4 * $urandom_range(0, 15));
        data_wdata = $urandom;
        data_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      end
      inst_req = i_pend;
      data_req = d_pend;
      reset = ($urandom_range(0, 39) == 0);
      to_neg();
      exp_gd = data_req && !reset;
      exp_gi = inst_req && !reset;
      if (exp_gi && exp_gd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_gd = ~last_win_d;
`else
        exp_gd = 1'b1;
`endif
        exp_gi = ~exp_gd;
      end
      exp_addr = exp_gd ? data_addr : inst_addr;
      exp_we = exp_gd ? data_we : 4'h0;
      checks++;
      ok = (inst_addr_ok === exp_gi) && (data_addr_ok === exp_gd) &&
           (sram_en === (exp_gi | exp_gd)) && (sram_we === ((exp_gi | exp_gd) ? exp_we : 4'h0));
      if (ok && (exp_gi || exp_gd)) ok = (sram_addr === exp_addr);
      if (ok && exp_gd && data_we != 4'h0) ok = (sram_wdata === data_wdata);
      if (!ok) begin
        errors++;
        $display("FAIL rand_grant cyc=%0d: iok=%b dok=%b en=%b we=%h addr=%h expected %b %b %h %h",
                 cyc, inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr, exp_gi, exp_gd,
                 exp_we, exp_addr);
      end
      checks++;
      ok = (inst_data_ok === (m_rv && !m_own_d && !reset)) &&
           (data_data_ok === (m_rv && m_own_d && !reset));
      ok = ok && (inst_rdata === ((m_rv && !m_own_d && !reset) ? m_rd : 32'h0));
      if (!(m_rv && m_own_d && !reset)) ok = ok && (data_rdata === 32'h0);
      else if (m_read) ok = ok && (data_rdata === m_rd);
      if (!ok) begin
        errors++;
        $display("FAIL rand_resp cyc=%0d: idok=%b ddok=%b ird=%h drd=%h expected v=%b own_d=%b rd=%h",
                 cyc, inst_data_ok, data_data_ok, inst_rdata, data_rdata, m_rv && !reset,
                 m_own_d, m_rd);
      end
      m_rv = exp_gi | exp_gd;
      m_own_d = exp_gd;
      m_read = exp_gi || (exp_gd && data_we == 4'h0);
      if (exp_gi || exp_gd) m_rd = ref_mem[widx(exp_addr)];
      if (exp_gd) begin
        for (int b = 0; b < 4; b++) begin
          if (data_we[b]) ref_mem[widx(data_addr)][8*b +: 8] = data_wdata[8*b +: 8];
        end
      end
      if (reset) last_win_d = 1'b0;
      else if (inst_req && data_req) last_win_d = exp_gd;
      if (exp_gi) i_pend = 1'b0;
      if (exp_gd) d_pend = 1'b0;
      to_pos();
    end
    reset = 1'b0;
    idle_inputs();
    to_pos();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, synchronous-read SRAM between the CPU's instruction-fetch requester and its load/store requester, so the multicycle core can run from a unified memory. Sits between the core's two request/response ports and the physical SRAM macro. One transaction is granted per cycle. Responses return exactly one cycle after the grant, tagged back to the requester that issued them.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.

Ports:
- `clk`  in  1: the single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `inst_req`  in  1: fetch request; held until `inst_addr_ok`.
- `inst_addr`  in  ADDR_W: fetch address, word aligned.
- `inst_addr_ok`  out  1: fetch request accepted this cycle.
- `inst_data_ok`  out  1: fetch data valid on `inst_rdata`.
- `inst_rdata`  out  DATA_W: fetch data.
- `data_req`  in  1: load/store request; held until `data_addr_ok`.
- `data_we`  in  DATA_W/8: byte write enables; all zero means read.
- `data_addr`  in  ADDR_W: load/store address.
- `data_wdata`  in  DATA_W: store data.
- `data_addr_ok`  out  1: load/store accepted this cycle.
- `data_data_ok`  out  1: load data valid, or store complete.
- `data_rdata`  out  DATA_W: load data.
- `sram_en`  out  1: SRAM access strobe.
- `sram_we`  out  DATA_W/8: SRAM byte write enables.
- `sram_addr`  out  ADDR_W: SRAM address.
- `sram_wdata`  out  DATA_W: SRAM write data.
- `sram_rdata`  in  DATA_W: SRAM read data, valid the cycle after `sram_en`.

## Operation
Grant (combinational from requests plus registered state):
- If exactly one of `inst_req`/`data_req` is high, that requester wins.
- If both are high, the winner follows the arbitration policy (see Configuration).
- The winner's `*_addr_ok` is high for one cycle.
- In the same cycle, `sram_en=1` and the winner's `we`/`addr`/`wdata` drive the SRAM. A fetch always drives `sram_we=0`.
- If there is no request: `sram_en=0`, `sram_we=0`; addr/wdata are don't-care and hold their last value.

Response tracking:
- Registers `resp_valid` and `resp_owner` (INST/DATA), loaded every cycle from the grant result.
- Cycle after a grant, `resp_valid=1`:
  - The owner's `*_data_ok` is high.
  - The owner's `*_rdata` equals `sram_rdata`, passed through combinationally.
  - The non-owner's `*_rdata` is 0.
- Stores also produce `data_data_ok`; `data_rdata` is then don't-care.

Pipelining:
- A new grant may occur in the same cycle as the previous response. Throughput is one access per cycle.
- No response backpressure: requesters must accept `*_data_ok` unconditionally.

Requester rules:
- `*_req` and its payload must stay stable from assertion until `*_addr_ok`.
- The arbiter does not check address alignment.

## Timing
Reset values, with reset asserted at cycle R, effective from R+1:
- `resp_valid=0`, `resp_owner=INST`, RR pointer=INST.
- All `*_addr_ok`, `*_data_ok`, `sram_en` are 0; `sram_we` is 0.
- While `reset=1`, no grants are issued.

Latency: request seen at cycle N with no contention → `addr_ok` at N → `data_ok` at N+1.

Contention: the loser waits at least one cycle per competing grant.

Reset mid-transaction: a grant in cycle G with reset at G+1 produces no `data_ok` at G+1 or later. The in-flight response is dropped. A store already strobed at G has written the SRAM.

Simultaneous grant and response in one cycle: legal, and the two may involve different owners.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On contention, the requester that did not win the most recent contended grant wins.
  - The 1-bit pointer updates only on contended grants.
  - Neither requester waits more than one cycle behind the other.
- Undefined: fixed priority, data always beats inst. There is no pointer register, and fetch may starve while `data_req` is held continuously.

## Structure
- Shared package/header `mem_arb_pkg`: owner encoding `OWN_INST=1'b0`, `OWN_DATA=1'b1`; default `ADDR_W`/`DATA_W` constants.
- One sub-module, `mem_arb_pick`: 2-way chooser taking `inst_req`, `data_req` and the pointer, returning a one-hot grant. It contains the macro-dependent logic.
- The top contains the SRAM mux, the response registers and the output demux.

## Test plan
- Lone fetch: `inst_req`, addr 0x1c000000, SRAM holds 0x02800421 → `inst_addr_ok` at N; `inst_data_ok` with rdata 0x02800421 at N+1; `data_*_ok` stay 0.
- Store then load: `data_we=4'hf`, addr 0x100, wdata 0xdeadbeef, then a read of 0x100 → `data_data_ok` at N+1 and at N+2; the N+2 rdata is 0xdeadbeef.
- Contention, macro off: both requests held for 3 cycles → three `data_addr_ok`, zero `inst_addr_ok`. Drop `data_req` → fetch is granted the next cycle.
- Contention, macro on: both held continuously → grants alternate DATA, INST, DATA, INST; responses are tagged with matching owners one cycle later.
- Reset mid-flight: fetch granted at G, `reset=1` at G+1 → `inst_data_ok=0` at G+1 and G+2; all outputs 0 at G+2.
- Back-to-back: fetches at 0x0, 0x4, 0x8 on consecutive cycles → three consecutive `inst_data_ok` with the matching words, no bubbles.
